// File: rtl/hex_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the A/B register pair.
// Freezes a snapshot while Hold is high and inserts dead time at each slot start.
module hex_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Aval,
  input  logic [7:0] Bval,
  input  logic       Hold,
  input  logic [3:0] Blank,
  output logic [7:0] hex_seg,
  output logic [3:0] hex_grid,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [3:0]    nib, nib_n;
  logic          blk, blk_n;
  logic [15:0]   snap, snap_n;
  logic          wrap;
  logic          dead;
  logic [7:0]    seg_n;
  logic [3:0]    grid_n;
  logic          tick_n;

  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // State register: outputs are registered from the post-edge slot state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      nib        <= 4'h0;
      blk        <= 1'b0;
      snap       <= 16'h0000;
      hex_seg    <= 8'hFF;
      hex_grid   <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      nib        <= nib_n;
      blk        <= blk_n;
      snap       <= snap_n;
      hex_seg    <= seg_n;
      hex_grid   <= grid_n;
      frame_tick <= tick_n;
    end
  end

  // Next state: the slot nibble comes from the snapshot as it stood before this edge.
  always_comb begin
    wrap   = (cnt == LAST);
    cnt_n  = wrap ? '0 : cnt + 1'b1;
    idx_n  = wrap ? idx + 2'd1 : idx;
    nib_n  = nib;
    blk_n  = blk;
    if (wrap) begin
      nib_n = snap[{idx_n, 2'b00} +: 4];
      blk_n = Blank[idx_n];
    end
    snap_n = Hold ? snap : {Aval, Bval};
    tick_n = wrap && (idx_n == 2'd0);
  end

  // Output decode from the state that will be current after this edge.
  always_comb begin
    dead   = int'(cnt_n) < DEAD_CYCLES;
    seg_n  = 8'hFF;
    grid_n = 4'hF;
    if (!dead && !blk_n) begin
      grid_n = ~(4'b0001 << idx_n);
      seg_n  = decode(nib_n);
    end
  end

endmodule
